// File: rtl/ofifo_sync.sv
// rtl/ofifo_sync.sv - multi-lane output FIFO with shared row pop (optional OFIFO_RELU_EN clamp)
module ofifo_sync #(
    parameter int col    = 8,
    parameter int bw     = 4,
    parameter int depth  = 64,
    parameter int aw     = 6,
    parameter int af_lvl = 56
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [col*bw-1:0]   in,
    input  logic [col-1:0]      wr,
    input  logic                rd,
`ifdef OFIFO_RELU_EN
    input  logic                relu,
`endif
    output logic [col*bw-1:0]   out,
    output logic                o_out_valid,
    output logic                o_valid,
    output logic                o_ready,
    output logic                o_full,
    output logic                o_afull,
    output logic [aw:0]         o_rows,
    output logic                o_err
);

    localparam logic [aw:0] full_cnt = (aw+1)'(depth);
    localparam logic [aw:0] af_cnt   = (aw+1)'(af_lvl);

    logic [bw-1:0]     mem [col][depth];
    logic [aw-1:0]     wp  [col];
    logic [aw:0]       cnt [col];
    logic [aw-1:0]     rp;

    logic [col-1:0]    wa;
    logic [col-1:0]    lane_full;
    logic [col-1:0]    lane_af;
    logic [aw:0]       rows_min;
    logic              ra;
    logic              overflow;
    logic              underflow;
    logic [col*bw-1:0] rd_row;

    // A row is complete only when the slowest lane has caught up, so rows = min count.
    always_comb begin
        rows_min = cnt[0];
        for (int i = 1; i < col; i++) begin
            if (cnt[i] < rows_min) rows_min = cnt[i];
        end
        for (int i = 0; i < col; i++) begin
            lane_full[i] = (cnt[i] == full_cnt);
            lane_af[i]   = (cnt[i] >= af_cnt);
        end
    end

    assign o_rows  = rows_min;
    assign o_valid = (rows_min != '0);
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign o_afull = |lane_af;

    assign ra = rd & o_valid;

    // A pop in the same cycle frees a slot, so a full lane may still accept.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            wa[i] = wr[i] & (~lane_full[i] | ra);
        end
    end

    assign overflow  = |(wr & ~wa);
    assign underflow = rd & ~o_valid;

    always_comb begin
        rd_row = '0;
        for (int i = 0; i < col; i++) begin
`ifdef OFIFO_RELU_EN
            if (relu && mem[i][rp][bw-1])
                rd_row[i*bw +: bw] = '0;
            else
                rd_row[i*bw +: bw] = mem[i][rp];
`else
            rd_row[i*bw +: bw] = mem[i][rp];
`endif
        end
    end

    // Storage has no reset; clearing the counts is what discards the contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (!reset && wa[i]) mem[i][wp[i]] <= in[i*bw +: bw];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rp          <= '0;
            out         <= '0;
            o_out_valid <= 1'b0;
            o_err       <= 1'b0;
            for (int i = 0; i < col; i++) begin
                wp[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            o_out_valid <= ra;
            if (ra) begin
                out <= rd_row;
                rp  <= rp + aw'(1);
            end
            for (int i = 0; i < col; i++) begin
                if (wa[i]) wp[i] <= wp[i] + aw'(1);
                cnt[i] <= cnt[i] + (aw+1)'(wa[i]) - (aw+1)'(ra);
            end
            if (overflow || underflow) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo_sync.sv
// tb/tb_ofifo_sync.sv - queue-model bench for ofifo_sync
module tb_ofifo_sync;
    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int DEP = 64;
    localparam int AFL = 56;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       in;
    logic [7:0]        wr;
    logic              rd;
    logic              relu_in;
    logic [31:0]       out;
    logic              o_out_valid, o_valid, o_ready, o_full, o_afull, o_err;
    logic [6:0]        o_rows;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [3:0]  mq [COL][$];
    logic [31:0] m_out = '0;
    logic        m_ov  = 1'b0;
    logic        m_err = 1'b0;

    ofifo_sync dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
`ifdef OFIFO_RELU_EN
        .relu(relu_in),
`endif
        .out(out), .o_out_valid(o_out_valid), .o_valid(o_valid), .o_ready(o_ready),
        .o_full(o_full), .o_afull(o_afull), .o_rows(o_rows), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int m_rows();
        int r = DEP + 1;
        for (int l = 0; l < COL; l++) if (mq[l].size() < r) r = mq[l].size();
        return r;
    endfunction

    function automatic logic [31:0] rowv(input int r);
        logic [31:0] v;
        for (int l = 0; l < COL; l++) v[l*4 +: 4] = 4'((r * 3 + l) % 16);
        return v;
    endfunction

    // Model: per-lane queues; a pop frees space before the same-cycle push is considered.
    always @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < COL; l++) mq[l].delete();
            m_out = '0;
            m_ov  = 1'b0;
            m_err = 1'b0;
        end else begin
            bit pop;
            logic [3:0] w;
            pop = rd && (m_rows() > 0);
            if (rd && !pop) m_err = 1'b1;
            if (pop) begin
                for (int l = 0; l < COL; l++) begin
                    w = mq[l].pop_front();
`ifdef OFIFO_RELU_EN
                    if (relu_in && w[3]) w = 4'h0;
`endif
                    m_out[l*4 +: 4] = w;
                end
            end
            m_ov = pop;
            for (int l = 0; l < COL; l++) begin
                if (wr[l]) begin
                    if (mq[l].size() < DEP) mq[l].push_back(in[l*4 +: 4]);
                    else m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit any_full, any_af;
            any_full = 1'b0;
            any_af   = 1'b0;
            for (int l = 0; l < COL; l++) begin
                if (mq[l].size() == DEP) any_full = 1'b1;
                if (mq[l].size() >= AFL) any_af = 1'b1;
            end
            chk("rows", 64'(o_rows), 64'(m_rows()));
            chk("valid", 64'(o_valid), 64'(m_rows() > 0));
            chk("full", 64'(o_full), 64'(any_full));
            chk("ready", 64'(o_ready), 64'(!any_full));
            chk("afull", 64'(o_afull), 64'(any_af));
            chk("err", 64'(o_err), 64'(m_err));
            chk("out_valid", 64'(o_out_valid), 64'(m_ov));
            chk("out", 64'(out), 64'(m_out));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; in = '0; relu_in = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("idle_valid", 64'(o_valid), 64'd0);
        chk("idle_ready", 64'(o_ready), 64'd1);
        chk("idle_rows", 64'(o_rows), 64'd0);
        chk("idle_err", 64'(o_err), 64'd0);
        chk("idle_out", 64'(out), 64'd0);

        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("underflow_err", 64'(o_err), 64'd1);
        chk("underflow_ov", 64'(o_out_valid), 64'd0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;

        in = 32'h87654321;
        for (int i = 0; i < COL; i++) begin
            wr = 8'(1 << i);
            cyc();
            if (i < COL - 1) chk("skew_valid_low", 64'(o_valid), 64'd0);
        end
        wr = '0;
        chk("skew_valid_high", 64'(o_valid), 64'd1);
        chk("skew_rows", 64'(o_rows), 64'd1);
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("skew_out", 64'(out), 64'h87654321);
        chk("skew_ov", 64'(o_out_valid), 64'd1);
        cyc();
        chk("skew_ov_pulse", 64'(o_out_valid), 64'd0);

        for (int r = 0; r < DEP; r++) begin
            in = rowv(r);
            wr = 8'hFF;
            cyc();
            if (r == 54) chk("afull_55", 64'(o_afull), 64'd0);
            if (r == 55) chk("afull_56", 64'(o_afull), 64'd1);
        end
        chk("full", 64'(o_full), 64'd1);
        chk("full_ready", 64'(o_ready), 64'd0);
        in = 32'hFFFFFFFF;
        cyc();
        wr = '0;
        chk("overflow_err", 64'(o_err), 64'd1);
        chk("overflow_rows", 64'(o_rows), 64'd64);

        in = rowv(DEP);
        wr = 8'hFF;
        rd = 1'b1;
        cyc();
        wr = '0;
        chk("fullpop_out", 64'(out), 64'h76543210);
        chk("fullpop_rows", 64'(o_rows), 64'd64);
        for (int k = 0; k < DEP; k++) begin
            cyc();
            chk("drain_out", 64'(out), 64'(rowv(k + 1)));
        end
        rd = 1'b0;
        cyc();
        chk("drained_rows", 64'(o_rows), 64'd0);

        wr = 8'hFF;
        for (int r = 0; r < 10; r++) begin
            in = rowv(r + 5);
            cyc();
        end
        wr = '0;
        chk("mid_rows", 64'(o_rows), 64'd10);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_rows", 64'(o_rows), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        in = 32'hA5C31E0F;
        wr = 8'hFF;
        cyc();
        wr = '0;
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("fresh_out", 64'(out), 64'hA5C31E0F);

`ifdef OFIFO_RELU_EN
        in = 32'h00000078;
        wr = 8'hFF;
        cyc();
        cyc();
        wr = '0;
        relu_in = 1'b1;
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("relu_on", 64'(out), 64'h00000070);
        relu_in = 1'b0;
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        chk("relu_off", 64'(out), 64'h00000078);
`endif

        cyc();
        cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofifo_sync.md
Name: ofifo_sync

Overview:
- Parametrised output FIFO for the systolic array's PE-column outputs; successor to the fixed depth-64 output FIFO.
- Each of `col` lanes is written independently by its PE column. Reads pop one complete row, one word from every lane, with a shared pointer.
- Adds configurable depth, row-occupancy count, almost-full flag, sticky overflow/underflow error and a registered read-data valid.
- Storage is internal; no sub-FIFO instances.

Parameters:
- col, 8, number of lanes (PE columns).
- bw, 4, bits per lane word.
- depth, 64, words per lane; power of two, at least 4.
- aw, 6, log2(depth).
- af_lvl, 56, almost-full threshold in words, 1..depth.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in  input  col*bw  write data; lane i occupies bits [(i+1)*bw-1 : i*bw].
- wr  input  col  per-lane write strobe.
- rd  input  1  row-pop request.
- out  output  col*bw  registered row data.
- o_out_valid  output  1  one-cycle pulse marking `out` as new.
- o_valid  output  1  at least one complete row is stored (all lanes non-empty).
- o_ready  output  1  no lane is full.
- o_full  output  1  any lane is full.
- o_afull  output  1  any lane count is at least af_lvl.
- o_rows  output  aw+1  number of complete rows (minimum lane count).
- o_err  output  1  sticky: overflow or underflow occurred.

Behaviour:
- State per lane: write pointer wp[i] (aw bits) and count cnt[i] (0..depth). One shared read pointer rp (aw bits). Pointers wrap modulo depth.
- Status outputs are all combinational from registered state:
  - o_rows = min over i of cnt[i]
  - o_valid = (o_rows != 0)
  - o_full = any cnt[i] == depth
  - o_ready = ~o_full
  - o_afull = any cnt[i] >= af_lvl
- Read:
  - Read accepted (ra) = rd & o_valid.
  - On ra: out <= the row stored at rp across all lanes; o_out_valid <= 1 on the next edge (latency 1); rp <= rp+1.
  - Without ra: o_out_valid <= 0 and out holds its value.
- Write to lane i:
  - Accepted (wa[i]) when wr[i] & (cnt[i] < depth | ra).
  - A full lane may be written in the same cycle as a pop.
  - On wa[i]: mem[i][wp[i]] <= in lane i; wp[i] <= wp[i]+1.
- Count update: cnt[i] <= cnt[i] + wa[i] - ra. A simultaneous write and pop leaves the count unchanged.
- Same-address write/read in one cycle (empty lane cannot be popped, so only full+pop case): read returns the old word, and the new word lands in the freed slot.
- Overflow: wr[i] & ~wa[i] drops the write and sets o_err.
- Underflow: rd & ~o_valid is ignored and sets o_err.
- o_err clears only on reset.
- Lanes may be written skewed in time (diagonal systolic drain). A row becomes poppable only once its last lane is written. o_valid rises the cycle after that write.
- Reset (any time, including mid-stream):
  - all pointers, counts, out, o_out_valid and o_err <= 0
  - stored contents discarded
  - wr/rd in the reset cycle ignored
  - after reset: o_valid=0, o_ready=1, o_full=0, o_afull=0, o_rows=0

Optional Feature:
- Macro: OFIFO_RELU_EN.
- When defined:
  - Adds input port `relu`, 1 bit.
  - On ra, each lane word is treated as signed bw-bit. If its MSB is 1 and relu=1, the registered `out` lane is 0; otherwise the word passes unchanged.
  - Stored memory is never modified.
- When undefined: no `relu` port, and `out` is the raw stored row.

Test Plan:
- Reset then idle:
  - o_valid=0, o_ready=1, o_rows=0, o_err=0, out=0.
  - rd=1 for one cycle -> o_err=1, no o_out_valid pulse.
- Skewed fill:
  - Write lane i at cycle t+i with value i+1 (col=8, bw=4).
  - o_valid stays 0 until the cycle after lane 7's write, then 1; o_rows=1.
  - rd -> out=0x87654321 one cycle later, o_out_valid=1 for exactly one cycle.
- Fill all lanes to 56 words -> o_afull=1. Continue to 64 -> o_full=1, o_ready=0.
  - Extra wr=0xFF -> writes dropped, o_err=1, o_rows stays 64.
- At full, wr=0xFF and rd in the same cycle:
  - Pop returns row 0, new row accepted, o_rows stays 64, o_err unchanged.
  - Then drain 64 rows in FIFO order, checking wrap-around across rp=63->0.
- Reset mid-stream with 10 rows stored:
  - Next cycle o_rows=0, o_valid=0, out=0.
  - A fresh row written afterwards reads back correctly.
- With OFIFO_RELU_EN:
  - Store lane words 0x8 and 0x7, relu=1 -> out lanes 0x0 and 0x7.
  - relu=0 -> 0x8 and 0x7.
